// File: rtl/udcounter_if.sv
// Control and status bundle for the up/down modulo counter.
// The counter sits on the slave side; whoever sequences it uses the master side.
interface udcounter_if #(
  parameter int N = 4
);
  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] d;
  logic [N-1:0] mod_val;
  logic         sat;
  logic [N-1:0] q;
  logic         tc;
  logic         wrap;

  modport master (
    output en, up, load, d, mod_val, sat,
    input  q, tc, wrap
  );

  modport slave (
    input  en, up, load, d, mod_val, sat,
    output q, tc, wrap
  );
endinterface

// File: rtl/udcounter.sv
// Up/down modulo counter with parallel load, wrap/saturate and a cascade terminal count.
// The count range is 0..mod_val; tc is combinational so a chained stage steps on the same edge.
module udcounter #(
  parameter int           N         = 4,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  udcounter_if.slave  bus
);

  logic [N-1:0] q_r;
  logic [N-1:0] q_nxt;
  logic         wrap_r;
  logic         wrap_nxt;
  logic         at_top;
  logic         at_zero;
  logic         above_top;
  logic [N-1:0] load_val;

  assign at_top    = (q_r >= bus.mod_val);
  assign above_top = (q_r >  bus.mod_val);
  assign at_zero   = (q_r == '0);
  assign load_val  = (bus.d > bus.mod_val) ? bus.mod_val : bus.d;

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    if (bus.load) begin
      q_nxt = load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (!at_top) begin
          q_nxt = q_r + 1'b1;
        end else if (bus.sat) begin
          q_nxt = bus.mod_val;
        end else begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        // Zero is checked first so mod_val = 0 with sat = 0 still wraps every step.
        if (at_zero) begin
          if (bus.sat) begin
            q_nxt = '0;
          end else begin
            q_nxt    = bus.mod_val;
            wrap_nxt = 1'b1;
          end
        end else if (above_top) begin
          q_nxt = bus.mod_val;
        end else begin
          q_nxt = q_r - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= RESET_VAL;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.tc   = bus.en & ~bus.load & (bus.up ? at_top : at_zero);

endmodule
